// File: rtl/parity_pkg.sv
// Shared definitions for the parity framed serial receiver.
package parity_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   ERR_CNT_W = 8;

endpackage

// File: rtl/parity_acc.sv
// Serial XOR accumulator: folds one bit per enable, clear has priority.
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_i,
    output logic par_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_o <= 1'b0;
        else if (clr)
            par_o <= 1'b0;
        else if (en)
            par_o <= par_o ^ bit_i;
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Strobed serial frame receiver: start, DATA_W bits LSB first, parity, stop.
// Define PARITY_RX_ERR_CNT_EN to add the saturating err_cnt_o error counter.
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int DATA_W     = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_en_i,
    input  logic              rx_bit_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              perr_o,
    output logic              ferr_o,
    output logic              busy_o
`ifdef PARITY_RX_ERR_CNT_EN
   ,output logic [ERR_CNT_W-1:0] err_cnt_o
`endif
);

    localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic            ODD      = (PARITY_ODD != 0);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] shreg;
    logic              par_run;
    logic              perr_pend;
    logic              acc_clr, acc_en, frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        frame_done = 1'b0;
        if (rx_en_i) begin
            case (state)
                IDLE: begin
                    if (rx_bit_i == START_BIT) begin
                        state_nxt = DATA;
                        acc_clr   = 1'b1;
                    end
                end
                DATA: begin
                    acc_en = 1'b1;
                    if (cnt == LAST_IDX)
                        state_nxt = PARITY;
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    parity_acc u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .bit_i (rx_bit_i),
        .par_o (par_run)
    );

    // Outputs are only touched on frame completion, so they hold between pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            shreg     <= '0;
            perr_pend <= 1'b0;
            data_o    <= '0;
            valid_o   <= 1'b0;
            perr_o    <= 1'b0;
            ferr_o    <= 1'b0;
        end else begin
            valid_o <= frame_done;
            if (acc_clr)
                cnt <= '0;
            if (acc_en) begin
                shreg[cnt] <= rx_bit_i;
                cnt        <= cnt + 1'b1;
            end
            if (rx_en_i && state == PARITY)
                perr_pend <= rx_bit_i != (par_run ^ ODD);
            if (frame_done) begin
                data_o <= shreg;
                perr_o <= perr_pend;
                ferr_o <= rx_bit_i != STOP_BIT;
            end
        end
    end

    assign busy_o = (state != IDLE);

`ifdef PARITY_RX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_o <= '0;
        else if (frame_done && (perr_pend || rx_bit_i != STOP_BIT) && err_cnt_o != '1)
            err_cnt_o <= err_cnt_o + 1'b1;
    end
`endif

endmodule

// File: tb/tb_parity_frame_rx.sv
// Random + directed frames against a queue-based frame model; even and odd parity DUTs.
module tb_parity_frame_rx;

    localparam int DW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_en_i = 1'b0;
    logic rx_bit_i = 1'b1;
    logic [DW-1:0] data_o, data2;
    logic valid_o, perr_o, ferr_o, busy_o;
    logic valid2, perr2, ferr2, busy2;
`ifdef PARITY_RX_ERR_CNT_EN
    logic [7:0] ecnt1, ecnt2;
`endif

    always #5 clk = ~clk;

    parity_frame_rx #(.DATA_W(DW), .PARITY_ODD(0)) dut (
        .clk(clk), .rst_n(rst_n), .rx_en_i(rx_en_i), .rx_bit_i(rx_bit_i),
        .data_o(data_o), .valid_o(valid_o), .perr_o(perr_o), .ferr_o(ferr_o), .busy_o(busy_o)
`ifdef PARITY_RX_ERR_CNT_EN
       ,.err_cnt_o(ecnt1)
`endif
    );

    parity_frame_rx #(.DATA_W(DW), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .rx_en_i(rx_en_i), .rx_bit_i(rx_bit_i),
        .data_o(data2), .valid_o(valid2), .perr_o(perr2), .ferr_o(ferr2), .busy_o(busy2)
`ifdef PARITY_RX_ERR_CNT_EN
       ,.err_cnt_o(ecnt2)
`endif
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          pe;
        logic          po;
        logic          fe;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    int total = 0, bad = 0, nvalid1 = 0, nvalid2 = 0, nfr = 0;
    logic [DW-1:0] ld1 = '0, ld2 = '0;
    logic lp1 = 1'b0, lp2 = 1'b0, lf1 = 1'b0, lf2 = 1'b0;
    int ec1 = 0, ec2 = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: each valid pulse retires the oldest completed frame; outputs hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_o) begin
                nvalid1++;
                chk("busy_at_valid", {31'd0, busy_o}, 32'd0);
                if (q1.size() == 0) chk("spurious_valid", 32'd1, 32'd0);
                else begin
                    e1 = q1.pop_front();
                    ld1 = e1.d; lp1 = e1.pe; lf1 = e1.fe;
                    if ((e1.pe || e1.fe) && ec1 < 255) ec1++;
                end
            end
            if (valid2) begin
                nvalid2++;
                chk("busy_at_valid_odd", {31'd0, busy2}, 32'd0);
                if (q2.size() == 0) chk("spurious_valid_odd", 32'd1, 32'd0);
                else begin
                    e2 = q2.pop_front();
                    ld2 = e2.d; lp2 = e2.po; lf2 = e2.fe;
                    if ((e2.po || e2.fe) && ec2 < 255) ec2++;
                end
            end
            chk("data", 32'(data_o), 32'(ld1));
            chk("perr", {31'd0, perr_o}, {31'd0, lp1});
            chk("ferr", {31'd0, ferr_o}, {31'd0, lf1});
            chk("data_odd", 32'(data2), 32'(ld2));
            chk("perr_odd", {31'd0, perr2}, {31'd0, lp2});
            chk("ferr_odd", {31'd0, ferr2}, {31'd0, lf2});
`ifdef PARITY_RX_ERR_CNT_EN
            chk("err_cnt", 32'(ecnt1), 32'(ec1));
            chk("err_cnt_odd", 32'(ecnt2), 32'(ec2));
`endif
        end
    end

    task automatic tick(input logic en, input logic b);
        @(posedge clk);
        #1;
        rx_en_i  = en;
        rx_bit_i = b;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b1, 1'b1);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic pb, input logic sb, input bit holes);
        logic [DW+2:0] bits;
        exp_t e;
        bits = {sb, pb, d, 1'b0};
        for (int i = 0; i < DW + 3; i++) begin
            if (holes) repeat ($urandom_range(0, 2)) tick(1'b0, 1'($urandom_range(0, 1)));
            if (i == DW + 2) begin
                e.d  = d;
                e.pe = (pb != ($countones(d) % 2 == 1));
                e.po = (pb != ($countones(d) % 2 == 0));
                e.fe = !sb;
                q1.push_back(e);
                q2.push_back(e);
                nfr++;
            end
            tick(1'b1, bits[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, 32'(data_o), 32'd0);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_perr"}, {31'd0, perr_o}, 32'd0);
        chk({tag, "_ferr"}, {31'd0, ferr_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_busy_odd"}, {31'd0, busy2}, 32'd0);
`ifdef PARITY_RX_ERR_CNT_EN
        chk({tag, "_errcnt"}, 32'(ecnt1), 32'd0);
`endif
    endtask

    logic [DW-1:0] rd;
    logic rp, rs;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // good frame 0xD, then wrong even parity (correct for odd)
        send_frame(4'hD, 1'b1, 1'b1, 1'b0);
        idle(3);
        send_frame(4'hD, 1'b0, 1'b1, 1'b0);
        idle(2);

        // framing error, then an immediately good frame
        send_frame(4'h5, 1'b0, 1'b0, 1'b0);
        send_frame(4'h6, 1'b0, 1'b1, 1'b1);
        idle(2);

        // reset after start + 2 data bits
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        @(posedge clk);
        #1;
        rx_en_i = 1'b0;
        chk("busy_mid_frame", {31'd0, busy_o}, 32'd1);
        rst_n = 1'b0;
        ld1 = '0; ld2 = '0; lp1 = 1'b0; lp2 = 1'b0; lf1 = 1'b0; lf2 = 1'b0;
        ec1 = 0; ec2 = 0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_frame(4'h0, 1'b0, 1'b1, 1'b0);
        idle(1);

        // back-to-back with short idle gaps, then zero gap
        send_frame(4'hA, 1'b0, 1'b1, 1'b0);
        idle($urandom_range(1, 3));
        send_frame(4'h3, 1'b0, 1'b1, 1'b0);
        send_frame(4'h9, 1'b0, 1'b1, 1'b0);
        idle($urandom_range(1, 3));

        repeat (40) begin
            rd = DW'($urandom);
            rp = 1'($urandom_range(0, 1));
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rd, rp, rs, 1'($urandom_range(0, 1)));
            idle($urandom_range(0, 3));
        end

`ifdef PARITY_RX_ERR_CNT_EN
        repeat (300) begin
            rd = DW'($urandom);
            send_frame(rd, ~(^rd), 1'b1, 1'b0);
        end
        idle(2);
        chk("errcnt_saturated", 32'(ecnt1), 32'd255);
        repeat (5) begin
            rd = DW'($urandom);
            send_frame(rd, ^rd, 1'b1, 1'b0);
        end
        idle(2);
        chk("errcnt_hold", 32'(ecnt1), 32'd255);
`endif

        tick(1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("frames_pending", q1.size(), 32'd0);
        chk("valid_count", 32'(nvalid1), 32'(nfr));
        chk("valid_count_odd", 32'(nvalid2), 32'(nfr));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
